npc_lsu: RTL and testbench

Parametrised load/store unit for the NPC core, replacing the fixed-mask, store-doubleword-only memory path of the single-cycle datapath. Accepts one load or store per request handshake from the execute stage, checks alignment, drives an aligned word-wide memory port with byte mask and lane shift, and returns sign- or zero-extended load data. The memory side tolerates arbitrary request-accept and response latency, so the same block serves DPI-backed simulation memory and a future bus bridge.

---
 rtl/npc_lsu_pkg.sv | 56 +++++
 rtl/npc_lsu_if.sv | 62 ++++++
 rtl/npc_lsu_align.sv | 49 ++++
 rtl/npc_lsu.sv | 134 +++++++++++++
 tb/tb_npc_lsu.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_lsu_pkg.sv
// npc_lsu shared types: access sizes, FSM states,
// and width-generic mask/extend helpers.
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int MAX_XLEN = 64;

  function automatic logic [7:0] size_mask(
    input logic [1:0] size
  );
    logic [7:0] m;
    m = 8'h01;
    unique case (size)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Extends at the widest width; callers
  // truncate to their own XLEN.
  function automatic logic [MAX_XLEN-1:0] extend(
    input logic [MAX_XLEN-1:0] v,
    input logic [1:0]          size,
    input logic                uns
  );
    logic [MAX_XLEN-1:0] r;
    r = v;
    unique case (size)
      SZ_B: r = uns ? {56'd0, v[7:0]}
                    : {{56{v[7]}}, v[7:0]};
      SZ_H: r = uns ? {48'd0, v[15:0]}
                    : {{48{v[15]}}, v[15:0]};
      SZ_W: r = uns ? {32'd0, v[31:0]}
                    : {{32{v[31]}}, v[31:0]};
      SZ_D: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_lsu_if.sv
// Execute-side and memory-side handshake bundles
// for the npc load/store unit.
interface npc_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface npc_lsu_mem_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/npc_lsu_align.sv
// Byte-lane steering: store shift/mask, load
// extract/extend and misalignment detect.
module npc_lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misalign
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int MW    = XLEN/8;

  logic [OFF_W-1:0]    off;
  logic [OFF_W+2:0]    sh;
  logic [XLEN-1:0]     rsh;
  logic [MAX_XLEN-1:0] rwide;
  logic [MAX_XLEN-1:0] ext;

  assign off      = addr_lo[OFF_W-1:0];
  assign sh       = {off, 3'b000};
  assign wdata_sh = wdata << sh;
  assign wmask    = MW'(size_mask(size)) << off;

  assign rsh       = rdata >> sh;
  assign rwide     = MAX_XLEN'(rsh);
  assign ext       = extend(rwide, size, uns);
  assign rdata_ext = ext[XLEN-1:0];

  // Doubleword has no lane on a 32-bit port.
  always_comb begin
    misalign = 1'b0;
    unique case (size)
      SZ_B: misalign = 1'b0;
      SZ_H: misalign = addr_lo[0];
      SZ_W: misalign = |addr_lo[1:0];
      SZ_D: misalign = (XLEN < 64) || (|addr_lo);
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// NPC load/store unit: request FSM, registered
// access fields and word-wide memory handshake.
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input logic            clk,
  input logic            rst,
  npc_lsu_if.slave       core,
  npc_lsu_mem_if.master  mem
);

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              idle;
  logic              in_req;
  logic              req_st;
  logic [2:0]        a_addr_lo;
  logic [1:0]        a_size;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN/8-1:0] wmask;
  logic [XLEN-1:0]   rdata_ext;
  logic              misalign;

  assign idle   = (state_q == S_IDLE);
  assign in_req = (state_q == S_REQ);
  assign req_st = in_req & we_q;

  // Alignment is judged on the live request while
  // idle, and on the captured fields afterwards.
  assign a_addr_lo = idle ? core.req_addr[2:0]
                          : addr_q[2:0];
  assign a_size    = idle ? core.req_size : size_q;

  npc_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .addr_lo   (a_addr_lo),
    .size      (a_size),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rdata     (mem.mem_rdata),
    .wdata_sh  (wdata_sh),
    .wmask     (wmask),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          we_d    = core.req_we;
          size_d  = core.req_size;
          uns_d   = core.req_unsigned;
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
          rdata_d = '0;
          err_d   = misalign;
          state_d = misalign ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          rdata_d = we_q ? '0 : rdata_ext;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (core.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core.req_ready  = idle;
  assign core.resp_valid = (state_q == S_RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  assign mem.mem_req_valid = in_req;
  assign mem.mem_we        = req_st;
  assign mem.mem_addr      = in_req ? (addr_q & ~OFF_MASK)
                                    : '0;
  assign mem.mem_wdata     = req_st ? wdata_sh : '0;
  assign mem.mem_wmask     = req_st ? wmask : '0;

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: vector table, random traffic
// against a byte-level model, and corner sequences.
module tb_npc_lsu;

  localparam logic [63:0] BASE = 64'h8000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  npc_lsu_if     #(.XLEN(64), .ADDR_W(64)) c ();
  npc_lsu_mem_if #(.XLEN(64), .ADDR_W(64)) m ();
  npc_lsu_if     #(.XLEN(32), .ADDR_W(64)) c32 ();
  npc_lsu_mem_if #(.XLEN(32), .ADDR_W(64)) m32 ();

  npc_lsu #(.XLEN(64), .ADDR_W(64)) u_dut (
    .clk (clk), .rst (rst), .core (c), .mem (m)
  );
  npc_lsu #(.XLEN(32), .ADDR_W(64)) u_dut32 (
    .clk (clk), .rst (rst), .core (c32), .mem (m32)
  );

  logic [7:0] mem_b [logic [63:0]];
  logic [7:0] ref_b [logic [63:0]];

  int          acc_delay = 0;
  int          resp_delay = 0;
  bit          mem_manual = 1'b0;
  int          mem_req_cnt = 0;
  bit          stable_bad = 1'b0;
  logic        last_we;
  logic [63:0] last_addr, last_wdata;
  logic [7:0]  last_wmask;
  int          phase = 0, cnt = 0, rcnt = 0;
  bit          in_req = 1'b0;
  logic [63:0] rd_word;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fill(input logic [63:0] a,
                      input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      mem_b[a + i] = w[8*i +: 8];
      ref_b[a + i] = w[8*i +: 8];
    end
  endtask

  // Reference: little-endian byte memory.
  function automatic logic [63:0] ref_load(
    input logic [63:0] a, input int sz, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++)
      if (ref_b.exists(a + i))
        v = v | (64'(ref_b[a + i]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1])
      v = v | ~((64'd1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a,
                           input int sz,
                           input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++)
      ref_b[a + i] = 8'((wd >> (8 * i)) & 64'hFF);
  endtask

  // Memory responder with programmable latencies.
  initial begin
    m.mem_req_ready  = 1'b0;
    m.mem_resp_valid = 1'b0;
    m.mem_rdata      = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_manual) begin
        phase = 0; in_req = 1'b0;
        m.mem_req_ready = 1'b0;
      end else if (rst) begin
        phase = 0; in_req = 1'b0;
        m.mem_req_ready  = 1'b0;
        m.mem_resp_valid = 1'b0;
      end else if (phase == 0) begin
        m.mem_req_ready  = 1'b0;
        m.mem_resp_valid = 1'b0;
        m.mem_rdata      = {$urandom, $urandom};
        if (m.mem_req_valid) begin
          if (!in_req) begin
            in_req = 1'b1; cnt = 0; mem_req_cnt++;
            last_we    = m.mem_we;
            last_addr  = m.mem_addr;
            last_wdata = m.mem_wdata;
            last_wmask = m.mem_wmask;
          end else if (m.mem_we !== last_we ||
                       m.mem_addr !== last_addr ||
                       m.mem_wdata !== last_wdata ||
                       m.mem_wmask !== last_wmask) begin
            stable_bad = 1'b1;
          end
          if (cnt >= acc_delay) begin
            m.mem_req_ready = 1'b1;
            phase = 1; rcnt = 0; in_req = 1'b0;
            for (int i = 0; i < 8; i++) begin
              if (m.mem_wmask[i])
                mem_b[m.mem_addr + i] = m.mem_wdata[8*i +: 8];
              rd_word[8*i +: 8] =
                mem_b.exists(m.mem_addr + i) ?
                mem_b[m.mem_addr + i] : 8'h00;
            end
          end else begin
            cnt++;
          end
        end
      end else begin
        m.mem_req_ready = 1'b0;
        if (rcnt >= resp_delay) begin
          m.mem_resp_valid = 1'b1;
          m.mem_rdata      = rd_word;
          phase = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic run_txn(
    input logic we, input logic [1:0] sz,
    input logic uns, input logic [63:0] a,
    input logic [63:0] wd, input int ad,
    input int rd, input int rr,
    output logic [63:0] rdata, output logic err,
    output int lat);
    bit bad;
    logic [63:0] hd;
    logic he;
    acc_delay = ad; resp_delay = rd;
    mem_req_cnt = 0; stable_bad = 1'b0; bad = 1'b0;
    check("req_ready_idle", 64'(c.req_ready), 1);
    c.req_valid = 1'b1; c.req_we = we;
    c.req_size = sz; c.req_unsigned = uns;
    c.req_addr = a; c.req_wdata = wd;
    @(posedge clk); #1;
    c.req_valid = 1'b0; c.req_we = ~we;
    c.req_size = ~sz; c.req_unsigned = ~uns;
    c.req_addr = ~a; c.req_wdata = ~wd;
    lat = 1;
    while (!c.resp_valid && lat < 40) begin
      if (c.req_ready) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("resp_timeout", 64'(c.resp_valid), 1);
    hd = c.resp_rdata; he = c.resp_err;
    for (int i = 0; i < rr; i++) begin
      if (c.req_ready) bad = 1'b1;
      @(posedge clk); #1;
      if (!c.resp_valid || c.resp_rdata !== hd ||
          c.resp_err !== he) bad = 1'b1;
    end
    if (c.req_ready) bad = 1'b1;
    c.resp_ready = 1'b1;
    rdata = c.resp_rdata; err = c.resp_err;
    @(posedge clk); #1;
    c.resp_ready = 1'b0;
    check("hold_and_busy", 64'(bad), 0);
    check("mem_stable", 64'(stable_bad), 0);
    check("post_resp_valid", 64'(c.resp_valid), 0);
    check("post_req_ready", 64'(c.req_ready), 1);
  endtask

  task automatic t32_load(
    input logic [1:0] sz, input logic uns,
    input logic [63:0] a, input logic [31:0] rd,
    output logic [31:0] res, output logic err,
    output int lat, output int nreq);
    bit issued;
    issued = 1'b0; nreq = 0;
    c32.req_valid = 1'b1; c32.req_we = 1'b0;
    c32.req_size = sz; c32.req_unsigned = uns;
    c32.req_addr = a; c32.req_wdata = '0;
    @(posedge clk); #1;
    c32.req_valid = 1'b0;
    lat = 1;
    while (!c32.resp_valid && lat < 10) begin
      if (m32.mem_req_valid) begin
        nreq++; m32.mem_req_ready = 1'b1; issued = 1'b1;
      end else if (issued) begin
        m32.mem_resp_valid = 1'b1; m32.mem_rdata = rd;
      end
      @(posedge clk); #1;
      m32.mem_req_ready = 1'b0;
      m32.mem_resp_valid = 1'b0;
      m32.mem_rdata = 32'h5A5A_A5A5;
      lat++;
    end
    res = c32.resp_rdata; err = c32.resp_err;
    c32.resp_ready = 1'b1;
    @(posedge clk); #1;
    c32.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wd;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] mwd;
    logic [7:0]  wm;
  } vec_t;

  vec_t tv [17];

  initial begin
    logic [63:0] r;
    logic        e;
    logic [31:0] r32;
    int          lat, nreq;
    bit          bad;

    c.req_valid = 0; c.req_we = 0; c.req_size = 0;
    c.req_unsigned = 0; c.req_addr = 0;
    c.req_wdata = 0; c.resp_ready = 0;
    c32.req_valid = 0; c32.req_we = 0; c32.req_size = 0;
    c32.req_unsigned = 0; c32.req_addr = 0;
    c32.req_wdata = 0; c32.resp_ready = 0;
    m32.mem_req_ready = 0; m32.mem_resp_valid = 0;
    m32.mem_rdata = 0;

    tv[0]  = '{0, 1, 0, BASE+6, 0, 0, 64'hFFFF_FFFF_FFFF_80FF, 0, 8'h00};
    tv[1]  = '{0, 1, 1, BASE+6, 0, 0, 64'h0000_0000_0000_80FF, 0, 8'h00};
    tv[2]  = '{0, 2, 0, BASE+2, 0, 1, 64'h0, 0, 8'h00};
    tv[3]  = '{1, 3, 0, BASE, 64'h1122_3344_5566_7788, 0, 64'h0,
               64'h1122_3344_5566_7788, 8'hFF};
    tv[4]  = '{1, 0, 0, BASE+5, 64'hAB, 0, 64'h0,
               64'h0000_AB00_0000_0000, 8'h20};
    tv[5]  = '{0, 0, 0, BASE+5, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 8'h00};
    tv[6]  = '{0, 0, 1, BASE+5, 0, 0, 64'h0000_0000_0000_00AB, 0, 8'h00};
    tv[7]  = '{0, 3, 1, BASE, 0, 0, 64'h1122_AB44_5566_7788, 0, 8'h00};
    tv[8]  = '{0, 2, 0, BASE+4, 0, 0, 64'h0000_0000_1122_AB44, 0, 8'h00};
    tv[9]  = '{0, 1, 0, BASE+1, 0, 1, 64'h0, 0, 8'h00};
    tv[10] = '{1, 3, 0, BASE+4, 64'h55, 1, 64'h0, 0, 8'h00};
    tv[11] = '{1, 1, 0, BASE+2, 64'hBEEF, 0, 64'h0,
               64'h0000_0000_BEEF_0000, 8'h0C};
    tv[12] = '{1, 2, 0, BASE+4, 64'hCAFE_F00D, 0, 64'h0,
               64'hCAFE_F00D_0000_0000, 8'hF0};
    tv[13] = '{0, 3, 0, BASE, 0, 0, 64'hCAFE_F00D_BEEF_7788, 0, 8'h00};
    tv[14] = '{0, 2, 0, BASE+4, 0, 0, 64'hFFFF_FFFF_CAFE_F00D, 0, 8'h00};
    tv[15] = '{0, 2, 1, BASE+4, 0, 0, 64'h0000_0000_CAFE_F00D, 0, 8'h00};
    tv[16] = '{0, 0, 0, BASE+7, 0, 0, 64'hFFFF_FFFF_FFFF_FFCA, 0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(c.req_ready), 1);
    check("rst_resp_valid", 64'(c.resp_valid), 0);
    check("rst_resp_err", 64'(c.resp_err), 0);
    check("rst_resp_rdata", c.resp_rdata, 0);
    check("rst_mem_req_valid", 64'(m.mem_req_valid), 0);
    check("rst_mem_we", 64'(m.mem_we), 0);
    check("rst_mem_addr", m.mem_addr, 0);
    check("rst_mem_wdata", m.mem_wdata, 0);
    check("rst_mem_wmask", 64'(m.mem_wmask), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(BASE, 64'h80FF_0000_0000_0000);
    for (int i = 0; i < 17; i++) begin
      run_txn(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr,
              tv[i].wd, 0, 0, 0, r, e, lat);
      check($sformatf("v%0d_err", i), 64'(e), 64'(tv[i].err));
      check($sformatf("v%0d_rdata", i), r, tv[i].rdata);
      check($sformatf("v%0d_lat", i), 64'(lat),
            tv[i].err ? 64'd1 : 64'd3);
      check($sformatf("v%0d_nreq", i), 64'(mem_req_cnt),
            tv[i].err ? 64'd0 : 64'd1);
      if (!tv[i].err) begin
        check($sformatf("v%0d_we", i), 64'(last_we), 64'(tv[i].we));
        check($sformatf("v%0d_maddr", i), last_addr, BASE);
        check($sformatf("v%0d_wmask", i), 64'(last_wmask),
              64'(tv[i].wm));
        if (tv[i].we)
          check($sformatf("v%0d_mwdata", i), last_wdata, tv[i].mwd);
      end
    end

    // Backpressure on request, response and result.
    run_txn(1, 2, 0, BASE+8, 64'hDEAD_BEEF, 4, 3, 2, r, e, lat);
    check("bp_st_lat", 64'(lat), 10);
    check("bp_st_err", 64'(e), 0);
    check("bp_st_wmask", 64'(last_wmask), 64'h0F);
    run_txn(0, 2, 0, BASE+8, 0, 4, 3, 2, r, e, lat);
    check("bp_ld_lat", 64'(lat), 10);
    check("bp_ld_rdata", r, 64'hFFFF_FFFF_DEAD_BEEF);

    for (int w = 0; w < 8; w++)
      fill(BASE + 64'(8 * w), {$urandom, $urandom});
    for (int k = 0; k < 80; k++) begin
      logic        we, uns, xerr;
      logic [1:0]  sz;
      logic [63:0] a, wd;
      int          ad, rd, off;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = BASE + 64'($urandom_range(0, 63));
      wd  = {$urandom, $urandom};
      ad  = $urandom_range(0, 2);
      rd  = $urandom_range(0, 2);
      off = int'(a % 8);
      xerr = (a % (64'd1 << sz)) != 0;
      run_txn(we, sz, uns, a, wd, ad, rd,
              $urandom_range(0, 2), r, e, lat);
      check($sformatf("r%0d_err", k), 64'(e), 64'(xerr));
      check($sformatf("r%0d_lat", k), 64'(lat),
            xerr ? 64'd1 : 64'(3 + ad + rd));
      if (xerr) begin
        check($sformatf("r%0d_rdata", k), r, 0);
        check($sformatf("r%0d_nreq", k), 64'(mem_req_cnt), 0);
      end else if (we) begin
        check($sformatf("r%0d_rdata", k), r, 0);
        check($sformatf("r%0d_maddr", k), last_addr,
              a - 64'(off));
        check($sformatf("r%0d_wmask", k), 64'(last_wmask),
              ((64'd1 << (1 << sz)) - 1) << off);
        check($sformatf("r%0d_mwdata", k), last_wdata,
              wd << (8 * off));
        ref_store(a, int'(sz), wd);
      end else begin
        check($sformatf("r%0d_rdata", k), r,
              ref_load(a, int'(sz), uns));
        check($sformatf("r%0d_wmask", k), 64'(last_wmask), 0);
      end
    end

    // Reset while waiting, then a stray completion.
    acc_delay = 0; resp_delay = 50;
    c.req_valid = 1'b1; c.req_we = 1'b0; c.req_size = 2'd3;
    c.req_unsigned = 1'b0; c.req_addr = BASE;
    @(posedge clk); #1;
    c.req_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", 64'(c.req_ready), 0);
    mem_manual = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_req_ready", 64'(c.req_ready), 1);
    check("midrst_mem_req", 64'(m.mem_req_valid), 0);
    m.mem_resp_valid = 1'b1; m.mem_rdata = 64'h1234_5678;
    @(posedge clk); #1;
    m.mem_resp_valid = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      if (c.resp_valid || c.resp_rdata != 0) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("stray_resp_ignored", 64'(bad), 0);
    check("stray_req_ready", 64'(c.req_ready), 1);
    mem_manual = 1'b0;
    @(posedge clk); #1;

    // 32-bit port.
    t32_load(3, 0, BASE, 32'h1, r32, e, lat, nreq);
    check("x32_d_err", 64'(e), 1);
    check("x32_d_lat", 64'(lat), 1);
    check("x32_d_nreq", 64'(nreq), 0);
    check("x32_d_rdata", 64'(r32), 0);
    t32_load(2, 0, BASE+4, 32'h8000_0001, r32, e, lat, nreq);
    check("x32_w_rdata", 64'(r32), 64'h8000_0001);
    check("x32_w_lat", 64'(lat), 3);
    t32_load(0, 0, BASE+3, 32'h9A00_0000, r32, e, lat, nreq);
    check("x32_b_rdata", 64'(r32), 64'hFFFF_FF9A);
    t32_load(1, 1, BASE+2, 32'hF00D_0000, r32, e, lat, nreq);
    check("x32_hu_rdata", 64'(r32), 64'h0000_F00D);
    check("x32_hu_err", 64'(e), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
